// File: rtl/buff_uart_mm.sv
`timescale 1ns/1ps
// Memory-mapped buffered UART with independent RX/TX FIFOs, sticky error flags and RX interrupt.
// Optional even parity on both directions when BUFF_UART_PARITY_EN is defined.
module buff_uart_mm #(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned RX_DEPTH       = 4,
   parameter int unsigned TX_DEPTH       = 4,
   parameter int unsigned ADDRESS_WIDTH  = 4,
   parameter int unsigned DATA_ADDRESS   = 0,
   parameter int unsigned STATUS_ADDRESS = 1,
   parameter int unsigned BAUD_RATE      = 9600,
   parameter int unsigned CLOCK_FREQ     = 460800
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx,
   output logic                     tx,
   input  logic [ADDRESS_WIDTH-1:0] address,
   input  logic                     read_enable,
   input  logic                     write_enable,
   input  logic [WIDTH-1:0]         write_data,
   output logic [WIDTH-1:0]         read_data,
   output logic                     rx_irq
);

   localparam int unsigned DIVISOR = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned CNT_W   = $clog2(DIVISOR);
   localparam int unsigned BIT_W   = $clog2(WIDTH + 1);
   localparam int unsigned RX_AW   = $clog2(RX_DEPTH);
   localparam int unsigned TX_AW   = $clog2(TX_DEPTH);
   localparam int unsigned RX_PW   = RX_AW + 1;
   localparam int unsigned TX_PW   = TX_AW + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd3;
`ifdef BUFF_UART_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd4;
`endif

   // register bus decode
   logic data_sel, status_sel, rd_data, wr_data, rd_status;
   assign data_sel   = (address == ADDRESS_WIDTH'(DATA_ADDRESS));
   assign status_sel = (address == ADDRESS_WIDTH'(STATUS_ADDRESS));
   assign rd_data    = read_enable && data_sel;
   assign wr_data    = write_enable && data_sel;
   assign rd_status  = read_enable && status_sel;

   // rx pin synchronizer
   logic rx_meta, rx_sync;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   // TX FIFO
   logic [WIDTH-1:0] tx_mem [TX_DEPTH];
   logic [TX_PW-1:0] tx_wr, tx_rd;
   logic             tx_empty, tx_full, tx_push_c, tx_pop_c, tx_ovf_set_c;
   logic [WIDTH-1:0] tx_head;
   assign tx_empty     = (tx_wr == tx_rd);
   assign tx_full      = ((tx_wr - tx_rd) == TX_PW'(TX_DEPTH));
   assign tx_head      = tx_mem[tx_rd[TX_AW-1:0]];
   assign tx_push_c    = wr_data && (!tx_full || tx_pop_c);
   assign tx_ovf_set_c = wr_data && tx_full && !tx_pop_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wr <= '0;
         tx_rd <= '0;
      end else begin
         if (tx_push_c) tx_wr <= tx_wr + TX_PW'(1);
         if (tx_pop_c)  tx_rd <= tx_rd + TX_PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push_c) tx_mem[tx_wr[TX_AW-1:0]] <= write_data;
   end

   // TX FSM
   logic [2:0]       tx_state, tx_state_n;
   logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
   logic [BIT_W-1:0] tx_bit, tx_bit_n;
   logic [WIDTH-1:0] tx_shift, tx_shift_n;
   logic             tx_line_c, tx_last, tx_busy;
`ifdef BUFF_UART_PARITY_EN
   logic             tx_par, tx_par_n;
`endif
   assign tx_last = (tx_cnt == CNT_W'(DIVISOR - 1));
   assign tx_busy = (tx_state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx       <= 1'b1;
`ifdef BUFF_UART_PARITY_EN
         tx_par   <= 1'b0;
`endif
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_bit   <= tx_bit_n;
         tx_shift <= tx_shift_n;
         tx       <= tx_line_c;
`ifdef BUFF_UART_PARITY_EN
         tx_par   <= tx_par_n;
`endif
      end
   end

   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_bit_n   = tx_bit;
      tx_shift_n = tx_shift;
      tx_pop_c   = 1'b0;
      tx_line_c  = 1'b1;
`ifdef BUFF_UART_PARITY_EN
      tx_par_n   = tx_par;
`endif
      case (tx_state)
         S_IDLE: begin
            if (!tx_empty) begin
               tx_pop_c   = 1'b1;
               tx_shift_n = tx_head;
               tx_cnt_n   = '0;
               tx_state_n = S_START;
`ifdef BUFF_UART_PARITY_EN
               tx_par_n   = ^tx_head;
`endif
            end
         end
         S_START: begin
            tx_line_c = 1'b0;
            if (tx_last) begin
               tx_cnt_n   = '0;
               tx_bit_n   = '0;
               tx_state_n = S_DATA;
            end else begin
               tx_cnt_n = tx_cnt + CNT_W'(1);
            end
         end
         S_DATA: begin
            tx_line_c = tx_shift[0];
            if (tx_last) begin
               tx_cnt_n   = '0;
               tx_shift_n = tx_shift >> 1;
               tx_bit_n   = tx_bit + BIT_W'(1);
               if (tx_bit == BIT_W'(WIDTH - 1)) begin
`ifdef BUFF_UART_PARITY_EN
                  tx_state_n = S_PARITY;
`else
                  tx_state_n = S_STOP;
`endif
               end
            end else begin
               tx_cnt_n = tx_cnt + CNT_W'(1);
            end
         end
`ifdef BUFF_UART_PARITY_EN
         S_PARITY: begin
            tx_line_c = tx_par;
            if (tx_last) begin
               tx_cnt_n   = '0;
               tx_state_n = S_STOP;
            end else begin
               tx_cnt_n = tx_cnt + CNT_W'(1);
            end
         end
`endif
         S_STOP: begin
            if (tx_last) begin
               tx_cnt_n   = '0;
               tx_state_n = S_IDLE;
            end else begin
               tx_cnt_n = tx_cnt + CNT_W'(1);
            end
         end
         default: tx_state_n = S_IDLE;
      endcase
   end

   // RX FSM
   logic [2:0]       rx_state, rx_state_n;
   logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
   logic [BIT_W-1:0] rx_bit, rx_bit_n;
   logic [WIDTH-1:0] rx_shift, rx_shift_n;
   logic             rx_last, rx_word_c, rx_err_c;
`ifdef BUFF_UART_PARITY_EN
   logic             rx_par_bad, rx_par_bad_n;
`endif
   assign rx_last = (rx_cnt == CNT_W'(DIVISOR - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state   <= S_IDLE;
         rx_cnt     <= '0;
         rx_bit     <= '0;
         rx_shift   <= '0;
`ifdef BUFF_UART_PARITY_EN
         rx_par_bad <= 1'b0;
`endif
      end else begin
         rx_state   <= rx_state_n;
         rx_cnt     <= rx_cnt_n;
         rx_bit     <= rx_bit_n;
         rx_shift   <= rx_shift_n;
`ifdef BUFF_UART_PARITY_EN
         rx_par_bad <= rx_par_bad_n;
`endif
      end
   end

   always_comb begin
      rx_state_n   = rx_state;
      rx_cnt_n     = rx_cnt;
      rx_bit_n     = rx_bit;
      rx_shift_n   = rx_shift;
      rx_word_c    = 1'b0;
      rx_err_c     = 1'b0;
`ifdef BUFF_UART_PARITY_EN
      rx_par_bad_n = rx_par_bad;
`endif
      case (rx_state)
         S_IDLE: begin
            if (!rx_sync) begin
               rx_cnt_n   = '0;
               rx_state_n = S_START;
`ifdef BUFF_UART_PARITY_EN
               rx_par_bad_n = 1'b0;
`endif
            end
         end
         S_START: begin
            // mid-start check rejects glitches shorter than half a bit
            if (rx_cnt == CNT_W'(DIVISOR / 2 - 1)) begin
               rx_cnt_n   = '0;
               rx_bit_n   = '0;
               rx_state_n = rx_sync ? S_IDLE : S_DATA;
            end else begin
               rx_cnt_n = rx_cnt + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (rx_last) begin
               rx_cnt_n   = '0;
               rx_shift_n = {rx_sync, rx_shift[WIDTH-1:1]};
               rx_bit_n   = rx_bit + BIT_W'(1);
               if (rx_bit == BIT_W'(WIDTH - 1)) begin
`ifdef BUFF_UART_PARITY_EN
                  rx_state_n = S_PARITY;
`else
                  rx_state_n = S_STOP;
`endif
               end
            end else begin
               rx_cnt_n = rx_cnt + CNT_W'(1);
            end
         end
`ifdef BUFF_UART_PARITY_EN
         S_PARITY: begin
            if (rx_last) begin
               rx_cnt_n     = '0;
               rx_par_bad_n = (^rx_shift) ^ rx_sync;
               rx_state_n   = S_STOP;
            end else begin
               rx_cnt_n = rx_cnt + CNT_W'(1);
            end
         end
`endif
         S_STOP: begin
            if (rx_last) begin
               rx_cnt_n   = '0;
               rx_state_n = S_IDLE;
`ifdef BUFF_UART_PARITY_EN
               if (rx_sync && !rx_par_bad) rx_word_c = 1'b1;
               else                        rx_err_c  = 1'b1;
`else
               if (rx_sync) rx_word_c = 1'b1;
               else         rx_err_c  = 1'b1;
`endif
            end else begin
               rx_cnt_n = rx_cnt + CNT_W'(1);
            end
         end
         default: rx_state_n = S_IDLE;
      endcase
   end

   // RX FIFO: a user pop in the same cycle frees room for the push
   logic [WIDTH-1:0] rx_mem [RX_DEPTH];
   logic [RX_PW-1:0] rx_wr, rx_rd, rx_wr_n, rx_rd_n;
   logic             rx_empty, rx_full, rx_push_c, rx_pop_c, rx_ovf_set_c;
   assign rx_empty     = (rx_wr == rx_rd);
   assign rx_full      = ((rx_wr - rx_rd) == RX_PW'(RX_DEPTH));
   assign rx_pop_c     = rd_data && !rx_empty;
   assign rx_push_c    = rx_word_c && (!rx_full || rx_pop_c);
   assign rx_ovf_set_c = rx_word_c && rx_full && !rx_pop_c;
   assign rx_wr_n      = rx_wr + RX_PW'(rx_push_c);
   assign rx_rd_n      = rx_rd + RX_PW'(rx_pop_c);

   always_ff @(posedge clk) begin
      if (rx_push_c) rx_mem[rx_wr[RX_AW-1:0]] <= rx_shift;
   end

   // sticky flags, read port and interrupt
   logic       rx_ovf, tx_ovf, rx_error;
   logic [7:0] status_c;
   assign status_c = {rx_error, tx_ovf, rx_ovf, tx_busy, tx_full, tx_empty, rx_full, rx_empty};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_wr     <= '0;
         rx_rd     <= '0;
         rx_ovf    <= 1'b0;
         tx_ovf    <= 1'b0;
         rx_error  <= 1'b0;
         read_data <= '0;
         rx_irq    <= 1'b0;
      end else begin
         rx_wr    <= rx_wr_n;
         rx_rd    <= rx_rd_n;
         rx_irq   <= (rx_wr_n != rx_rd_n);
         rx_ovf   <= (rx_ovf   && !rd_status) || rx_ovf_set_c;
         tx_ovf   <= (tx_ovf   && !rd_status) || tx_ovf_set_c;
         rx_error <= (rx_error && !rd_status) || rx_err_c;
         if (read_enable) begin
            if (data_sel)        read_data <= rx_empty ? '0 : rx_mem[rx_rd[RX_AW-1:0]];
            else if (status_sel) read_data <= WIDTH'(status_c);
            else                 read_data <= '0;
         end
      end
   end

endmodule

// File: tb/tb_buff_uart_mm.sv
`timescale 1ns/1ps
// Scoreboard bench for buff_uart_mm: register reads and transmitted frames are checked by monitors.
module tb_buff_uart_mm;

`ifdef BUFF_UART_PARITY_EN
   localparam int FRAME = 528;
   logic bad_parity = 1'b0;
`else
   localparam int FRAME = 480;
`endif

   logic       clk = 1'b0;
   logic       rst, rx, tx;
   logic [3:0] address;
   logic       read_enable, write_enable;
   logic [7:0] write_data, read_data;
   logic       rx_irq;

   int tests  = 0;
   int errors = 0;

   logic [7:0] exp_rd [$];
   string      exp_tag [$];
   logic [7:0] tx_exp [$];

   buff_uart_mm dut (
      .clk(clk), .rst(rst), .rx(rx), .tx(tx),
      .address(address), .read_enable(read_enable), .write_enable(write_enable),
      .write_data(write_data), .read_data(read_data), .rx_irq(rx_irq)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n, inout logic ab);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (rst) ab = 1'b1;
      end
   endtask

   task automatic bus_read(input logic [3:0] a, input logic [7:0] e, input string name);
      @(negedge clk);
      address = a; read_enable = 1'b1;
      exp_rd.push_back(e); exp_tag.push_back(name);
      @(negedge clk);
      read_enable = 1'b0;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      address = a; write_data = d; write_enable = 1'b1;
      @(negedge clk);
      write_enable = 1'b0;
   endtask

   // stop_low > 0 drives a shortened low stop bit (framing error) of that many clocks
   task automatic send_rx(input logic [7:0] d, input int stop_low);
      @(negedge clk);
      rx = 1'b0; repeat (48) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i]; repeat (48) @(negedge clk);
      end
`ifdef BUFF_UART_PARITY_EN
      rx = (^d) ^ bad_parity; repeat (48) @(negedge clk);
`endif
      if (stop_low > 0) begin
         rx = 1'b0; repeat (stop_low) @(negedge clk);
      end
      rx = 1'b1; repeat (48) @(negedge clk);
   endtask

   task automatic wait_irq();
      for (int i = 0; i < 100 && !rx_irq; i++) @(negedge clk);
   endtask

   // read monitor: read_data is due one clock after the strobe
   initial begin
      logic [7:0] e;
      string      n;
      forever begin
         @(posedge clk);
         if (read_enable && !rst) begin
            #1;
            if (exp_rd.size() == 0) begin
               check("unexpected_read", 32'(read_data), 32'hFFFF_FFFF);
            end else begin
               e = exp_rd.pop_front();
               n = exp_tag.pop_front();
               check(n, 32'(read_data), 32'(e));
            end
         end
      end
   end

   // tx monitor: samples each bit mid-cell, abandons a frame cut by reset
   initial begin
      logic [7:0] b;
      logic       ab, stop_bit;
      forever begin
         @(negedge tx);
         if (!rst) begin
            ab = 1'b0;
            b  = '0;
            wait_clk(24, ab);
            if (!ab) check("tx_start_mid", 32'(tx), 32'd0);
            for (int i = 0; i < 8; i++) begin
               wait_clk(48, ab);
               b[i] = tx;
            end
`ifdef BUFF_UART_PARITY_EN
            wait_clk(48, ab);
            if (!ab) check("tx_parity", 32'(tx), 32'(^b));
`endif
            wait_clk(48, ab);
            stop_bit = tx;
            if (!ab) begin
               if (tx_exp.size() == 0) begin
                  check("tx_unexpected_frame", 32'(b), 32'hFFFF_FFFF);
               end else begin
                  check("tx_byte", 32'(b), 32'(tx_exp.pop_front()));
                  check("tx_stop", 32'(stop_bit), 32'd1);
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1; rx = 1'b1; address = '0;
      read_enable = 1'b0; write_enable = 1'b0; write_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_read_data", 32'(read_data), 32'd0);
      check("reset_rx_irq", 32'(rx_irq), 32'd0);
      bus_read(4'd1, 8'h05, "status_after_reset");

      // transmit 0xA5 and check start latency and bit length
      tx_exp.push_back(8'hA5);
      @(negedge clk);
      address = 4'd0; write_data = 8'hA5; write_enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      write_enable = 1'b0;
      @(posedge clk); #1 check("tx_edge_n1", 32'(tx), 32'd1);
      @(posedge clk); #1 check("tx_edge_n2", 32'(tx), 32'd0);
      repeat (47) @(posedge clk);
      #1 check("tx_start_len", 32'(tx), 32'd0);
      @(posedge clk); #1 check("tx_bit0", 32'(tx), 32'd1);
      repeat (50) @(negedge clk);
      bus_read(4'd1, 8'h15, "status_tx_busy");
      repeat (FRAME) @(negedge clk);
      bus_read(4'd1, 8'h05, "status_tx_done");

      // TX overflow: one word in flight, four fill the FIFO, the next is dropped
      tx_exp.push_back(8'h11); tx_exp.push_back(8'h22); tx_exp.push_back(8'h33);
      tx_exp.push_back(8'h44); tx_exp.push_back(8'h55);
      bus_write(4'd0, 8'h11);
      repeat (4) @(negedge clk);
      bus_write(4'd0, 8'h22); bus_write(4'd0, 8'h33); bus_write(4'd0, 8'h44);
      bus_write(4'd0, 8'h55); bus_write(4'd0, 8'h66);
      bus_read(4'd1, 8'h59, "status_tx_overflow");
      bus_read(4'd1, 8'h19, "status_tx_ovf_cleared");
      repeat (5 * (FRAME + 1) + 40) @(negedge clk);
      check("tx_queue_drained", 32'(tx_exp.size()), 32'd0);
      bus_read(4'd1, 8'h05, "status_tx_drained");

      // RX single frame
      send_rx(8'h3C, 0);
      wait_irq();
      check("rx_irq_set", 32'(rx_irq), 32'd1);
      bus_read(4'd0, 8'h3C, "rx_data_3c");
      check("rx_irq_clear", 32'(rx_irq), 32'd0);
      bus_read(4'd1, 8'h05, "status_rx_empty");
      bus_read(4'd0, 8'h00, "rx_read_empty");

      // framing error
      send_rx(8'h5A, 30);
      check("rx_irq_frame_err", 32'(rx_irq), 32'd0);
      bus_read(4'd1, 8'h85, "status_frame_err");
      bus_read(4'd1, 8'h05, "status_err_cleared");
`ifdef BUFF_UART_PARITY_EN
      bad_parity = 1'b1;
      send_rx(8'h5A, 0);
      bad_parity = 1'b0;
      bus_read(4'd1, 8'h85, "status_parity_err");
      bus_read(4'd1, 8'h05, "status_parity_cleared");
`endif

      // RX overflow: five frames into four entries
      for (int i = 1; i <= 5; i++) send_rx(8'(i), 0);
      check("rx_irq_full", 32'(rx_irq), 32'd1);
      bus_read(4'd1, 8'h26, "status_rx_overflow");
      bus_read(4'd0, 8'h01, "rx_fifo_0");
      bus_read(4'd0, 8'h02, "rx_fifo_1");
      bus_read(4'd0, 8'h03, "rx_fifo_2");
      bus_read(4'd0, 8'h04, "rx_fifo_3");
      bus_read(4'd0, 8'h00, "rx_fifo_empty");
      bus_read(4'd1, 8'h05, "status_rx_drained");
      check("rx_irq_drained", 32'(rx_irq), 32'd0);

      // unmapped read and ignored status write
      bus_read(4'd5, 8'h00, "unmapped_read");
      bus_write(4'd1, 8'hFF);
      repeat (100) @(negedge clk);
      check("status_write_no_tx", 32'(tx), 32'd1);
      bus_read(4'd1, 8'h05, "status_after_status_write");

      // simultaneous read and write, then reset mid-frame
      send_rx(8'h99, 0);
      send_rx(8'h42, 0);
      @(negedge clk);
      address = 4'd0; write_data = 8'h7E; read_enable = 1'b1; write_enable = 1'b1;
      exp_rd.push_back(8'h99); exp_tag.push_back("rx_data_with_write");
      @(negedge clk);
      read_enable = 1'b0; write_enable = 1'b0;
      repeat (20) @(negedge clk);
      check("tx_low_before_reset", 32'(tx), 32'd0);
      check("rx_irq_before_reset", 32'(rx_irq), 32'd1);
      rst = 1'b1;
      #1;
      check("tx_high_on_reset", 32'(tx), 32'd1);
      check("rx_irq_on_reset", 32'(rx_irq), 32'd0);
      check("read_data_on_reset", 32'(read_data), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      bus_read(4'd1, 8'h05, "status_after_midframe_reset");
      bus_read(4'd0, 8'h00, "rx_discarded");
      repeat (FRAME) @(negedge clk);
      check("tx_idle_after_reset", 32'(tx), 32'd1);
      check("read_queue_drained", 32'(exp_rd.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
